// File: rtl/proc_mem_run_ctrl_pkg.sv
// Shared definitions for the processor memory / run-control companion block:
// FSM state encoding, word width, instruction opcodes and small helpers.
package proc_mem_run_ctrl_pkg;

  localparam int WORD_W = 16;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } run_state_e;

  // Processor opcodes (IR[8:6]), used when building program images.
  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/proc_mem_run_ctrl_sync_ram_1rw.sv
// DEPTH x DATA_W RAM: one synchronous write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module sync_ram_1rw #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Array write; contents are deliberately not reset so preloads survive Reset.
  always_ff @(posedge Clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the output register alone is cleared by Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdata <= {DATA_W{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/proc_mem_run_ctrl.sv
// Memory and Run/Done initiator for the processor: supplies DIN, absorbs
// stores, lets a host preload the RAM, starts the processor and halts it on
// stop request, instruction budget or watchdog timeout.
module proc_mem_run_ctrl
  import proc_mem_run_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 256,
  parameter logic [15:0] MAX_INSTR = 16'hFFFF,
  parameter int          TIMEOUT   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              stop,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  input  logic              Done,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       instr_count
);

  localparam int                WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  run_state_e        state_r;
  run_state_e        state_nxt_s;
  logic [WD_W-1:0]   watchdog_r;
  logic [WD_W-1:0]   watchdog_nxt_s;
  logic              stop_pending_r;
  logic              stop_pending_nxt_s;
  logic              timeout_err_r;
  logic              timeout_err_nxt_s;
  logic              run_r;
  logic              busy_r;
  logic [15:0]       instr_count_r;
  logic [15:0]       count_nxt_s;
  logic [15:0]       count_inc_s;

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [15:0]       ram_wdata_s;
  logic [ADDR_W-1:0] ram_raddr_s;
  logic              unused_addr_hi_s;

  // Only the low ADDR bits select a word; the rest wrap.
  assign ram_raddr_s      = ADDR[ADDR_W-1:0];
  assign unused_addr_hi_s = ^ADDR[15:ADDR_W];

  // Write-port owner: processor stores while running, host preload otherwise.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = ld_addr;
    ram_wdata_s = ld_data;
    case (state_r)
      ST_RUN: begin
        ram_we_s    = W;
        ram_waddr_s = ADDR[ADDR_W-1:0];
        ram_wdata_s = DOUT;
      end
      ST_IDLE, ST_HALT: begin
        ram_we_s    = ld_we;
        ram_waddr_s = ld_addr;
        ram_wdata_s = ld_data;
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ld_addr;
        ram_wdata_s = ld_data;
      end
    endcase
  end

  sync_ram_1rw #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W)
  ) u_ram (
    .Clock (Clock),
    .Reset (Reset),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .rdata (DIN)
  );

  assign count_inc_s = sat_inc(instr_count_r);

  // Next-state logic: start/Done/stop handling and the no-Done watchdog.
  always_comb begin
    state_nxt_s        = state_r;
    count_nxt_s        = instr_count_r;
    watchdog_nxt_s     = watchdog_r;
    stop_pending_nxt_s = stop_pending_r;
    timeout_err_nxt_s  = timeout_err_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt_s        = ST_RUN;
          count_nxt_s        = 16'd0;
          watchdog_nxt_s     = {WD_W{1'b0}};
          stop_pending_nxt_s = 1'b0;
          timeout_err_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (Done) begin
          // A completed instruction beats a simultaneous timeout.
          count_nxt_s    = count_inc_s;
          watchdog_nxt_s = {WD_W{1'b0}};
          if (stop_pending_r || stop || (count_inc_s == MAX_INSTR)) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          if (stop) begin
            stop_pending_nxt_s = 1'b1;
          end else begin
            stop_pending_nxt_s = stop_pending_r;
          end
          if (watchdog_r == WD_LAST) begin
            state_nxt_s       = ST_HALT;
            timeout_err_nxt_s = 1'b1;
          end else begin
            watchdog_nxt_s = watchdog_r + {{(WD_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and status registers; Run/busy track the state being entered.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r        <= ST_IDLE;
      instr_count_r  <= 16'd0;
      watchdog_r     <= {WD_W{1'b0}};
      stop_pending_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      run_r          <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      instr_count_r  <= count_nxt_s;
      watchdog_r     <= watchdog_nxt_s;
      stop_pending_r <= stop_pending_nxt_s;
      timeout_err_r  <= timeout_err_nxt_s;
      run_r          <= (state_nxt_s == ST_RUN);
      busy_r         <= (state_nxt_s == ST_RUN);
    end
  end

  assign Run         = run_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_proc_mem_run_ctrl.sv
// Directed bench for proc_mem_run_ctrl: preload/readback, Run/Done counting,
// stop handling, watchdog, store/load gating, budget halt and async reset.
module tb_proc_mem_run_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ld_we = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_data = 16'd0;
  logic [15:0] ADDR = 16'd0;
  logic [15:0] DOUT = 16'd0;
  logic        W = 1'b0;
  logic        Done = 1'b0;
  logic [15:0] DIN;
  logic        Run;
  logic        busy;
  logic        timeout_err;
  logic [15:0] instr_count;

  int n_vec  = 0;
  int n_miss = 0;

  proc_mem_run_ctrl #(
    .ADDR_W    (8),
    .DEPTH     (256),
    .MAX_INSTR (16'd5),
    .TIMEOUT   (8)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .start       (start),
    .stop        (stop),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ADDR        (ADDR),
    .DOUT        (DOUT),
    .W           (W),
    .Done        (Done),
    .DIN         (DIN),
    .Run         (Run),
    .busy        (busy),
    .timeout_err (timeout_err),
    .instr_count (instr_count)
  );

  always #5 Clock = ~Clock;

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    check_vec("rst_run", Run, 1'b0);
    check_vec("rst_busy", busy, 1'b0);
    check_vec("rst_terr", timeout_err, 1'b0);
    check_vec("rst_cnt", instr_count, 16'd0);
    check_vec("rst_din", DIN, 16'd0);
    Reset = 1'b0;

    // Preload in IDLE and read back, including address wrap
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = 16'h1234;
    tick(1);
    ld_addr = 8'd9; ld_data = 16'hA5A5;
    tick(1);
    ld_we = 1'b0; ADDR = 16'd5;
    tick(1);
    check_vec("preload_rd5", DIN, 16'h1234);
    ADDR = 16'h0105;
    tick(1);
    check_vec("wrap_rd105", DIN, 16'h1234);

    // Read during write returns the old word, new word next cycle
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = 16'h5678; ADDR = 16'd5;
    tick(1);
    check_vec("rdw_old", DIN, 16'h1234);
    ld_we = 1'b0;
    tick(1);
    check_vec("rdw_new", DIN, 16'h5678);

    // Start and count three Done pulses with gaps below TIMEOUT
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_vec("start_run", Run, 1'b1);
    check_vec("start_busy", busy, 1'b1);
    Done = 1'b1; tick(1); Done = 1'b0;
    check_vec("done1_cnt", instr_count, 16'd1);
    tick(2);
    Done = 1'b1; tick(1); Done = 1'b0;
    tick(3);
    check_vec("gap_run", Run, 1'b1);
    Done = 1'b1; tick(1); Done = 1'b0;
    check_vec("done3_cnt", instr_count, 16'd3);
    check_vec("done3_run", Run, 1'b1);

    // start while running is ignored
    start = 1'b1; tick(1); start = 1'b0;
    check_vec("start_in_run_cnt", instr_count, 16'd3);

    // stop and Done together halt on that edge
    stop = 1'b1; Done = 1'b1;
    tick(1);
    stop = 1'b0; Done = 1'b0;
    check_vec("stopdone_run", Run, 1'b0);
    check_vec("stopdone_busy", busy, 1'b0);
    check_vec("stopdone_cnt", instr_count, 16'd4);

    // stop without Done waits for the next Done
    start = 1'b1; tick(1); start = 1'b0;
    check_vec("restart_cnt", instr_count, 16'd0);
    stop = 1'b1; tick(1); stop = 1'b0;
    check_vec("stop_pend_run", Run, 1'b1);
    tick(1);
    Done = 1'b1; tick(1); Done = 1'b0;
    check_vec("stop_halt_run", Run, 1'b0);
    check_vec("stop_halt_cnt", instr_count, 16'd1);

    // W in HALT does not touch RAM
    W = 1'b1; ADDR = 16'd5; DOUT = 16'hDEAD;
    tick(1);
    W = 1'b0;
    tick(1);
    check_vec("halt_w_ignored", DIN, 16'h5678);

    // Watchdog: eight cycles without Done
    start = 1'b1; tick(1); start = 1'b0;
    tick(7);
    check_vec("wd_7_run", Run, 1'b1);
    check_vec("wd_7_terr", timeout_err, 1'b0);
    tick(1);
    check_vec("wd_8_run", Run, 1'b0);
    check_vec("wd_8_terr", timeout_err, 1'b1);
    tick(2);
    check_vec("wd_sticky", timeout_err, 1'b1);
    start = 1'b1; tick(1); start = 1'b0;
    check_vec("wd_clear_terr", timeout_err, 1'b0);
    check_vec("wd_clear_run", Run, 1'b1);

    // Processor store lands; host preload in RUN is ignored
    W = 1'b1; ADDR = 16'd7; DOUT = 16'hBEEF;
    tick(1);
    W = 1'b0;
    ld_we = 1'b1; ld_addr = 8'd9; ld_data = 16'h0BAD;
    tick(1);
    ld_we = 1'b0; ADDR = 16'd7;
    tick(1);
    check_vec("st_rd7", DIN, 16'hBEEF);
    ADDR = 16'd9;
    tick(1);
    check_vec("ldwe_in_run", DIN, 16'hA5A5);

    // Instruction budget: back-to-back Done until MAX_INSTR
    Done = 1'b1;
    tick(4);
    check_vec("budget4_run", Run, 1'b1);
    tick(1);
    Done = 1'b0;
    check_vec("budget5_run", Run, 1'b0);
    check_vec("budget5_cnt", instr_count, 16'd5);

    // Asynchronous reset mid-run
    start = 1'b1; tick(1); start = 1'b0;
    Done = 1'b1; tick(1); Done = 1'b0;
    check_vec("pre_rst_cnt", instr_count, 16'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_vec("arst_run", Run, 1'b0);
    check_vec("arst_busy", busy, 1'b0);
    check_vec("arst_cnt", instr_count, 16'd0);
    tick(1);
    Reset = 1'b0;
    ADDR = 16'd9;
    tick(1);
    check_vec("arst_ram9", DIN, 16'hA5A5);
    ADDR = 16'd7;
    tick(1);
    check_vec("arst_ram7", DIN, 16'hBEEF);
    check_vec("arst_idle_run", Run, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
